// File: rtl/dispatcher_pkg.sv
// Shared types and constants for the task dispatcher: FSM encoding,
// default sizing and the saturating counter helper.
package dispatcher_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RUN    = 2'd2,
      RETIRE = 2'd3
   } state_t;

   localparam int DEF_WIDTH        = 5;
   localparam int DEF_TIME_QUANTUM = 2;
   localparam int CNT_W            = 8;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/task_dispatcher_onehot_encoder.sv
// Grant vector to binary index; flags a clean one-hot grant and a multi-hot
// (illegal) grant separately so the FSM can tell "none" from "bad".
module onehot_encoder #(
   parameter int WIDTH = 5,
   parameter int IDX_W = 3
) (
   input  logic [WIDTH-1:0] grant,
   output logic [IDX_W-1:0] index,
   output logic             valid,
   output logic             error
);

   always_comb begin
      index = '0;
      for (int i = 0; i < WIDTH; i++)
         if (grant[i]) index = index | IDX_W'(i);
      valid = $onehot(grant);
      error = (grant != '0) && !valid;
   end

endmodule

// File: rtl/task_dispatcher.sv
// Hands one granted requester at a time to a coprocessor, bounds its run
// time with a quantum, and reports completion, preemption and bad grants.
module task_dispatcher
   import dispatcher_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int TIME_QUANTUM = DEF_TIME_QUANTUM,
   parameter int IDX_W        = 3
) (
   input  logic             in_clk,
   input  logic             in_reset,
   input  logic [WIDTH-1:0] in_grant,
   input  logic             in_ready,
   input  logic             in_done,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_index,
   output logic [WIDTH-1:0] out_ack,
   output logic             out_preempt,
   output logic             out_error,
   output logic             out_busy,
   output logic [CNT_W-1:0] out_preempt_count
);

   state_t             state, state_d;
   logic [CNT_W-1:0]   qcnt, qcnt_d, pcnt_d;
   logic [IDX_W-1:0]   index_d, enc_idx;
   logic [WIDTH-1:0]   ack_d;
   logic               valid_d, preempt_d, error_d, busy_d;
   logic               enc_vld, enc_err;

   onehot_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
      .grant (in_grant),
      .index (enc_idx),
      .valid (enc_vld),
      .error (enc_err)
   );

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) state <= IDLE;
      else          state <= state_d;
   end

   // Every output is computed one cycle ahead and registered below.
   always_comb begin
      state_d   = state;
      qcnt_d    = qcnt;
      index_d   = out_index;
      pcnt_d    = out_preempt_count;
      valid_d   = 1'b0;
      ack_d     = '0;
      preempt_d = 1'b0;
      error_d   = 1'b0;
      case (state)
         IDLE: begin
            if (enc_vld) begin
               index_d = enc_idx;
               valid_d = 1'b1;
               state_d = ISSUE;
            end else if (enc_err && !out_error) begin
               // A bad grant held for several cycles must not stretch the pulse.
               error_d = 1'b1;
            end
         end
         ISSUE: begin
            if (in_ready) begin
               qcnt_d  = CNT_W'(TIME_QUANTUM);
               state_d = RUN;
            end else begin
               valid_d = 1'b1;
            end
         end
         RUN: begin
            qcnt_d = qcnt - CNT_W'(1);
            if (in_done) begin
               qcnt_d  = '0;
               ack_d   = WIDTH'(1) << out_index;
               state_d = RETIRE;
            end else if (qcnt <= CNT_W'(1)) begin
               qcnt_d    = '0;
               preempt_d = 1'b1;
               pcnt_d    = sat_inc(out_preempt_count);
               state_d   = IDLE;
            end
         end
         RETIRE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         qcnt              <= '0;
         out_valid         <= 1'b0;
         out_index         <= '0;
         out_ack           <= '0;
         out_preempt       <= 1'b0;
         out_error         <= 1'b0;
         out_busy          <= 1'b0;
         out_preempt_count <= '0;
      end else begin
         qcnt              <= qcnt_d;
         out_valid         <= valid_d;
         out_index         <= index_d;
         out_ack           <= ack_d;
         out_preempt       <= preempt_d;
         out_error         <= error_d;
         out_busy          <= busy_d;
         out_preempt_count <= pcnt_d;
      end
   end

endmodule
